// File: rtl/s1_frame_tx_if.sv
// RB1 read-port bundle between the frame transmitter (master) and the
// 32x8 synchronous RAM (slave). Signal names follow the RAM's pin names.
interface s1_frame_tx_if;
  logic       RB1_RW;
  logic [4:0] RB1_A;
  logic [7:0] RB1_D;
  logic [7:0] RB1_Q;

  modport master (
    output RB1_RW,
    output RB1_A,
    output RB1_D,
    input  RB1_Q
  );

  modport slave (
    input  RB1_RW,
    input  RB1_A,
    input  RB1_D,
    output RB1_Q
  );
endinterface

// File: rtl/s1_frame_tx.sv
// s1_frame_tx: reads RB1 bytes 0..17 into a local buffer, then sends the
// buffer as 8 serial frames. Frame n is a 3-bit index followed by bit (7-n)
// of every byte, byte 0 first. Frames are separated by a one-cycle gap.
// After the last frame the block idles until the next reset.
module s1_frame_tx (
  input  logic           clk,
  input  logic           rst,
  s1_frame_tx_if.master  rb1,
  output logic           sen,
  output logic           sd
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    SEND,
    GAP,
    DONE
  } state_t;

  localparam logic [4:0] LAST_ADDR  = 5'd17;  // highest RB1 address read
  localparam logic [4:0] RD_END     = 5'd18;  // extra cycle for the RAM latency
  localparam logic [4:0] BIT_LAST   = 5'd20;  // 21 bits per frame
  localparam logic [4:0] HDR_BITS   = 5'd3;   // frame index width
  localparam logic [2:0] FRAME_LAST = 3'd7;

  state_t     state, state_n;
  logic [4:0] rd_cnt, rd_cnt_n;
  logic [2:0] frame, frame_n;
  logic [4:0] bit_cnt, bit_cnt_n;
  logic       sen_n, sd_n;
  logic [4:0] data_k;
  logic [7:0] buf_mem [0:17];

  // The port is read-only; the address follows the read counter and holds
  // the last address through the latency cycle and afterwards.
  assign rb1.RB1_RW = 1'b1;
  assign rb1.RB1_D  = 8'h00;
  assign rb1.RB1_A  = (rd_cnt > LAST_ADDR) ? LAST_ADDR : rd_cnt;

  // Next-state, next-counter and next-output logic.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_n   = state;
    rd_cnt_n  = rd_cnt;
    frame_n   = frame;
    bit_cnt_n = bit_cnt;

    case (state)
      IDLE: begin
        state_n  = READ;
        rd_cnt_n = '0;
      end
      READ: begin
        if (rd_cnt == RD_END) begin
          state_n   = SEND;
          frame_n   = '0;
          bit_cnt_n = '0;
        end else begin
          rd_cnt_n = rd_cnt + 5'd1;
        end
      end
      SEND: begin
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_n = '0;
          if (frame == FRAME_LAST) begin
            state_n = DONE;
          end else begin
            state_n = GAP;
            frame_n = frame + 3'd1;
          end
        end else begin
          bit_cnt_n = bit_cnt + 5'd1;
        end
      end
      GAP: begin
        state_n   = SEND;
        bit_cnt_n = '0;
      end
      DONE: begin
        state_n = DONE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    // Serial outputs are computed for the coming cycle so they can be
    // registered: index bits MSB first, then data bits 17..0.
    data_k = bit_cnt_n - HDR_BITS;
    sen_n  = (state_n != SEND);
    sd_n   = 1'b0;
    if (state_n == SEND) begin
      if (bit_cnt_n < HDR_BITS) begin
        sd_n = frame_n[2'd2 - bit_cnt_n[1:0]];
      end else begin
        sd_n = buf_mem[data_k][3'd7 - frame_n];
      end
    end
  end

  // State, counters and registered serial outputs.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      frame   <= '0;
      bit_cnt <= '0;
      sen     <= 1'b1;
      sd      <= 1'b0;
    end else begin
      state   <= state_n;
      rd_cnt  <= rd_cnt_n;
      frame   <= frame_n;
      bit_cnt <= bit_cnt_n;
      sen     <= sen_n;
      sd      <= sd_n;
    end
  end

  // Capture byte (rd_cnt-1): its address was sampled one edge earlier.
  // NOTE: this buffer is deliberately cleared by reset so a restarted run
  // never transmits stale bytes; that keeps it in flops rather than RAM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 18; i++) begin
        buf_mem[i] <= '0;
      end
    end else if (state == READ && rd_cnt != 5'd0) begin
      buf_mem[rd_cnt - 5'd1] <= rb1.RB1_Q;
    end
  end

endmodule

// File: tb/tb_s1_frame_tx.sv
// Self-checking bench for s1_frame_tx: a behavioural RB1 RAM, directed and
// random RAM images, a frame receiver on the serial pins and a reference
// model that builds each expected frame from the RAM contents.
module tb_s1_frame_tx;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sen;
  logic sd;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ram [0:31];

  s1_frame_tx_if rb1 ();

  s1_frame_tx dut (
    .clk (clk),
    .rst (rst),
    .rb1 (rb1),
    .sen (sen),
    .sd  (sd)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: address sampled on the rising edge, data valid after it.
  always @(posedge clk) rb1.RB1_Q <= ram[rb1.RB1_A];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected frame n: index n, then bit (7-n) of bytes 0..17 in that order.
  function automatic logic [20:0] exp_frame(input int n);
    logic [17:0] data;
    logic [2:0]  idx;
    data = '0;
    idx  = 3'(n);
    for (int k = 0; k < 18; k++) data[17 - k] = ram[k][7 - n];
    return {idx, data};
  endfunction

  task automatic fill_rand();
    for (int i = 0; i < 32; i++) ram[i] = 8'($urandom_range(0, 255));
  endtask

  // Called at a negedge: holds reset for one rising edge, checks reset outputs.
  task automatic do_reset(input string tag);
    rst = 1'b0;
    @(negedge clk);
    check({tag, ":rst_sen"}, 32'(sen), 32'd1);
    check({tag, ":rst_sd"}, 32'(sd), 32'd0);
    check({tag, ":rst_addr"}, 32'(rb1.RB1_A), 32'd0);
    check({tag, ":rst_rw"}, 32'(rb1.RB1_RW), 32'd1);
    check({tag, ":rst_d"}, 32'(rb1.RB1_D), 32'd0);
    rst = 1'b1;
  endtask

  // Receives frames after reset release. With abort_n >= 0 it returns while
  // bit 10 of frame abort_n is on sd, leaving the caller to reset.
  task automatic collect(input string tag, input int abort_n, output bit aborted);
    int         edges      = 0;
    int         first_low  = -1;
    int         nf         = 0;
    int         len        = 0;
    int         gap        = 0;
    int         idle_after = 0;
    logic [20:0] sh        = '0;
    logic       prev_sen   = 1'b1;
    aborted = 1'b0;
    while (edges < 1500) begin
      @(negedge clk);
      edges++;
      check({tag, ":rw"}, 32'(rb1.RB1_RW), 32'd1);
      check({tag, ":wdata"}, 32'(rb1.RB1_D), 32'd0);
      if (edges <= 18) check({tag, ":addr"}, 32'(rb1.RB1_A), 32'(edges - 1));
      if (sen === 1'b0) begin
        if (first_low < 0) begin
          first_low = edges;
          // 1 edge leaves IDLE, 19 READ cycles, then the first bit.
          check({tag, ":first_bit_cycle"}, 32'(edges), 32'd20);
        end
        if (nf >= 8) check({tag, ":extra_frame_sen"}, 32'(sen), 32'd1);
        if (prev_sen && nf > 0) check({tag, ":gap_len"}, 32'(gap), 32'd1);
        sh = {sh[19:0], sd};
        len++;
        if (nf == abort_n && len == 11) begin
          aborted = 1'b1;
          return;
        end
      end else begin
        check({tag, ":idle_sd"}, 32'(sd), 32'd0);
        if (!prev_sen) begin
          check({tag, $sformatf(":frame%0d_len", nf)}, 32'(len), 32'd21);
          check({tag, $sformatf(":frame%0d", nf)}, 32'(sh), 32'(exp_frame(nf)));
          nf++;
          len = 0;
          gap = 0;
        end
        gap++;
        if (nf == 8) begin
          idle_after++;
          if (idle_after == 30) begin
            check({tag, ":frame_count"}, 32'(nf), 32'd8);
            return;
          end
        end
      end
      prev_sen = sen;
    end
    check({tag, ":done_in_budget"}, 32'(idle_after), 32'd30);
  endtask

  task automatic run(input string tag);
    bit ab;
    do_reset(tag);
    collect(tag, -1, ab);
  endtask

  initial begin
    bit ab;

    fill_rand();
    for (int k = 0; k < 18; k++) ram[k] = 8'h00;
    run("zeros");

    fill_rand();
    for (int k = 0; k < 18; k++) ram[k] = 8'h00;
    ram[0] = 8'h80;
    run("msb_byte0");

    fill_rand();
    for (int k = 0; k < 18; k++) ram[k] = 8'h00;
    ram[17] = 8'h01;
    run("lsb_byte17");

    fill_rand();
    for (int k = 0; k < 18; k++) ram[k] = 8'hFF;
    run("ones");

    for (int r = 0; r < 3; r++) begin
      fill_rand();
      run($sformatf("rand%0d", r));
    end

    // Reset during bit 10 of frame 3; new RAM contents prove the re-read.
    fill_rand();
    do_reset("abort");
    collect("abort", 3, ab);
    check("abort:reached_frame3_bit10", 32'(ab), 32'd1);
    fill_rand();
    do_reset("abort_edge");
    collect("restart", -1, ab);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/s1_frame_tx.md
S1_FRAME_TX -- requirements
Module: s1_frame_tx

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  reset: one clock; reset is synchronous and active-low.
REQ-004 RB1_RW  output  1  RB1 write-enable-n; 1 = read, 0 = write.
REQ-005 RB1_A  output  5  RB1 address.
REQ-006 RB1_D  output  8  RB1 write data.
REQ-007 RB1_Q  input  8  RB1 read data.
REQ-008 sen  output  1  serial frame enable, active-low; 1 = idle, 0 = frame bit on sd.
REQ-009 sd  output  1  serial data, one bit per clock while sen = 0.

Function
REQ-010 SHALL treat RB1 as a 32x8 synchronous RAM: RB1_A sampled on a rising edge, RB1_Q valid after that edge, held until the next address is sampled.
REQ-011 SHALL only read RB1: RB1_RW fixed at 1, RB1_D fixed at 8'h00.
REQ-012 SHALL read RB1 addresses 0..17 in ascending order, capturing all 18 bytes (144 bits) into an internal buffer before transmitting anything.
REQ-013 SHALL account for the one-cycle read latency when capturing; the byte for address k is captured from RB1_Q after address k has been sampled.
REQ-014 SHALL then transmit exactly 8 frames, n = 0..7, in ascending order.
REQ-015 Frame n SHALL be 21 bits: a 3-bit frame index equal to n, then 18 data bits.
REQ-016 Data bit (17-k) of frame n, for k = 0..17, SHALL equal bit (7-n) of RB1 byte k.
REQ-017 Example: frame 0 data bit 17 = RB1[0] bit 7; frame 7 data bit 0 = RB1[17] bit 0.
REQ-018 Each frame SHALL be sent MSB first: index bits 2..0, then data bits 17..0.
REQ-019 Frame bits SHALL occupy 21 consecutive cycles with sen = 0.
REQ-020 sen and sd SHALL be registered and change only after a rising edge, so a receiver sampling on the rising edge sees a stable bit.
REQ-021 Between consecutive frames, sen SHALL be 1 for exactly one cycle, with sd = 0.
REQ-022 After frame 7 completes, sen SHALL stay 1 and sd SHALL stay 0 until the next reset (DONE state).
REQ-023 State machine: IDLE -> READ (addresses 0..17 plus one latency cycle) -> SEND (21 bit cycles) -> GAP (1 cycle) -> SEND for the next frame. After frame 7, SEND -> DONE.
REQ-024 Internal counters: 5-bit read address, 3-bit frame index, 5-bit bit counter (0..20). None SHALL wrap past its terminal value.

Reset
REQ-025 While rst = 0 at a rising edge, outputs SHALL become: sen = 1, sd = 0, RB1_A = 0, RB1_RW = 1, RB1_D = 0.
REQ-026 While rst = 0 at a rising edge, the state SHALL become IDLE and all counters and the buffer SHALL clear.
REQ-027 On the first rising edge with rst = 1, the block SHALL leave IDLE and start READ at address 0.
REQ-028 Reset asserted mid-read or mid-frame SHALL abort the operation immediately (sen = 1 after that edge).
REQ-029 After such a reset, a full restart SHALL follow: re-read RB1 from address 0, then send from frame 0.

Verification
REQ-030 RB1 all 8'h00 -> frames n = 0..7, each index n, data 18'h00000; then sen held at 1.
REQ-031 RB1[0] = 8'h80, others 0 -> frame 0 data 18'h20000; frames 1..7 data 18'h00000.
REQ-032 RB1[17] = 8'h01, others 0 -> frame 7 data 18'h00001; frames 0..6 data 18'h00000.
REQ-033 RB1[0..17] = 8'hFF -> every frame data 18'h3FFFF; exactly 21 low-sen cycles per frame, one-cycle gaps, 8 frames total.
REQ-034 Reset pulse during bit 10 of frame 3 -> sen = 1 after the reset edge; RB1 re-read from address 0; transmission restarts at frame 0 with correct data.
REQ-035 Throughout all scenarios, check RB1_RW = 1 and RB1_D = 8'h00 on every cycle.
